// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit multiplexed seven-segment scan controller with per-frame snapshot,
// leading-zero blanking, PWM brightness, dead time and frame tick. Define SEG_SCAN_HEX_DEC_EN for A-F glyphs.
module seg_scan_ctrl #(
   parameter int NUM_DIGIT = 6,
   parameter int SCAN_DIV  = 50000,
   parameter int DEAD_CYC  = 2,
   parameter int BRIGHT_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4*NUM_DIGIT-1:0] i_digit,
   input  logic [NUM_DIGIT-1:0]   i_dp,
   input  logic                   i_blank_lz,
   input  logic [BRIGHT_W-1:0]    i_bright,
   output logic [6:0]             o_seg,
   output logic                   o_seg_dp,
   output logic [NUM_DIGIT-1:0]   o_seg_enb,
   output logic                   o_frame_tick
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGIT > 1) ? $clog2(NUM_DIGIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGIT - 1);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [BRIGHT_W-1:0]    pwm_q, pwm_d;
   logic [4*NUM_DIGIT-1:0] snap_digit_q;
   logic [NUM_DIGIT-1:0]   snap_dp_q;
   logic                   snap_blz_q;
   logic [6:0]             seg_q, seg_d;
   logic                   seg_dp_q, seg_dp_d;
   logic [NUM_DIGIT-1:0]   enb_q, enb_d;
   logic                   tick_q, tick_d;

   logic [NUM_DIGIT-1:0]   blank_mask;
   logic                   lead;
   logic [3:0]             cur_digit;
   logic                   cur_dp;
   logic                   cur_blank;
   logic                   enb_on;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1110011;
`ifdef SEG_SCAN_HEX_DEC_EN
         4'd10:   s = 7'b1110111;
         4'd11:   s = 7'b0011111;
         4'd12:   s = 7'b1001110;
         4'd13:   s = 7'b0111101;
         4'd14:   s = 7'b1001111;
         4'd15:   s = 7'b1000111;
`endif
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      pwm_d = pwm_q + 1'b1;
   end

   // Walk down from the most significant digit; the first nonzero digit or lit dp ends the blanked run.
   always_comb begin
      lead       = snap_blz_q;
      blank_mask = '0;
      for (int k = NUM_DIGIT - 1; k >= 1; k--) begin
         if (lead && (snap_digit_q[4*k +: 4] == 4'd0) && !snap_dp_q[k]) begin
            blank_mask[k] = 1'b1;
         end else begin
            lead = 1'b0;
         end
      end
   end

   always_comb begin
      cur_digit = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      enb_d     = '1;
      enb_on    = (cnt_q >= CNT_DEAD) && (pwm_q <= i_bright);
      for (int k = 0; k < NUM_DIGIT; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_digit = snap_digit_q[4*k +: 4];
            cur_dp    = snap_dp_q[k];
            cur_blank = blank_mask[k];
            enb_d[k]  = ~enb_on;
         end
      end
      seg_d    = cur_blank ? 7'b0000000 : decode(cur_digit);
      seg_dp_d = cur_dp & ~cur_blank;
      tick_d   = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
   end

   // Inputs are captured only at the very start of a frame so a digit never changes mid-frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         snap_digit_q <= '0;
         snap_dp_q    <= '0;
         snap_blz_q   <= 1'b0;
         seg_q        <= '0;
         seg_dp_q     <= 1'b0;
         enb_q        <= '1;
         tick_q       <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         pwm_q    <= pwm_d;
         seg_q    <= seg_d;
         seg_dp_q <= seg_dp_d;
         enb_q    <= enb_d;
         tick_q   <= tick_d;
         if ((idx_q == '0) && (cnt_q == '0)) begin
            snap_digit_q <= i_digit;
            snap_dp_q    <= i_dp;
            snap_blz_q   <= i_blank_lz;
         end
      end
   end

   assign o_seg        = seg_q;
   assign o_seg_dp     = seg_dp_q;
   assign o_seg_enb    = enb_q;
   assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with an arithmetic scan model checked every cycle,
// plus literal expectations per scenario. Honours SEG_SCAN_HEX_DEC_EN for the hex glyph case.
module tb_seg_scan_ctrl;

   localparam int ND = 6;
   localparam int SD = 8;
   localparam int DC = 2;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [4*ND-1:0] i_digit;
   logic [ND-1:0] i_dp;
   logic          i_blank_lz;
   logic [BW-1:0] i_bright;
   logic [6:0]    o_seg;
   logic          o_seg_dp;
   logic [ND-1:0] o_seg_enb;
   logic          o_frame_tick;

   int checkCount = 0;
   int passCount  = 0;
   int ncount     = 0;

   typedef struct packed {
      logic [ND-1:0] enb;
      logic [6:0]    seg;
      logic          dp;
      logic          tick;
   } expT;

   expT             expOut;
   bit              modelValid = 1'b0;
   int              sModel;
   logic [4*ND-1:0] snapDig;
   logic [ND-1:0]   snapDp;
   logic            snapBlz;

   seg_scan_ctrl #(
      .NUM_DIGIT(ND),
      .SCAN_DIV (SD),
      .DEAD_CYC (DC),
      .BRIGHT_W (BW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_digit     (i_digit),
      .i_dp        (i_dp),
      .i_blank_lz  (i_blank_lz),
      .i_bright    (i_bright),
      .o_seg       (o_seg),
      .o_seg_dp    (o_seg_dp),
      .o_seg_enb   (o_seg_enb),
      .o_frame_tick(o_frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] segOf(input int v);
      case (v)
         0:  return 7'b1111110;
         1:  return 7'b0110000;
         2:  return 7'b1101101;
         3:  return 7'b1111001;
         4:  return 7'b0110011;
         5:  return 7'b1011011;
         6:  return 7'b1011111;
         7:  return 7'b1110000;
         8:  return 7'b1111111;
         9:  return 7'b1110011;
`ifdef SEG_SCAN_HEX_DEC_EN
         10: return 7'b1110111;
         11: return 7'b0011111;
         12: return 7'b1001110;
         13: return 7'b0111101;
         14: return 7'b1001111;
         15: return 7'b1000111;
`endif
         default: return 7'b0000000;
      endcase
   endfunction

   // Output for scan step s (cycles since reset): slot, digit and pwm phase all follow from s directly.
   function automatic expT modelOut(input int s, input logic [4*ND-1:0] dig, input logic [ND-1:0] dp,
                                    input logic blz, input logic [BW-1:0] bright);
      expT e;
      int  cnt, idx, pwm, d;
      bit  blanked;
      cnt   = s % SD;
      idx   = (s / SD) % ND;
      pwm   = s % (1 << BW);
      e.enb = '1;
      if (cnt >= DC && pwm <= int'(bright)) e.enb[idx] = 1'b0;
      blanked = blz && (idx != 0);
      for (int j = idx; j < ND; j++) begin
         if (dig[4*j +: 4] != 4'd0 || dp[j]) blanked = 1'b0;
      end
      d      = int'(dig[4*idx +: 4]);
      e.seg  = blanked ? 7'b0000000 : segOf(d);
      e.dp   = blanked ? 1'b0 : dp[idx];
      e.tick = (idx == ND - 1) && (cnt == SD - 1);
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         modelValid <= 1'b1;
         sModel     <= 0;
         snapDig    <= '0;
         snapDp     <= '0;
         snapBlz    <= 1'b0;
         expOut     <= '{enb: '1, seg: 7'b0000000, dp: 1'b0, tick: 1'b0};
      end else if (modelValid) begin
         expOut <= modelOut(sModel, snapDig, snapDp, snapBlz, i_bright);
         if (sModel % (SD * ND) == 0) begin
            snapDig <= i_digit;
            snapDp  <= i_dp;
            snapBlz <= i_blank_lz;
         end
         sModel <= sModel + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checkCount++;
      if (act === want) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
   endtask

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("modelEnb", 32'(o_seg_enb), 32'(expOut.enb));
         checkOutput("modelTick", 32'(o_frame_tick), 32'(expOut.tick));
         if (expOut.enb != '1) begin
            checkOutput("modelSeg", 32'(o_seg), 32'(expOut.seg));
            checkOutput("modelDp", 32'(o_seg_dp), 32'(expOut.dp));
         end
      end
   end

   task automatic applyStimulus(input logic [4*ND-1:0] dig, input logic [ND-1:0] dp,
                                input logic blz, input logic [BW-1:0] bright);
      i_digit    = dig;
      i_dp       = dp;
      i_blank_lz = blz;
      i_bright   = bright;
   endtask

   task automatic stepTo(input int target);
      while (ncount < target) begin
         @(negedge clk);
         ncount++;
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ncount = 0;
   endtask

   task automatic checkLit(input string name, input logic [ND-1:0] enb, input logic [6:0] seg, input logic dp);
      checkOutput({name, "Enb"}, 32'(o_seg_enb), 32'(enb));
      checkOutput({name, "Seg"}, 32'(o_seg), 32'(seg));
      checkOutput({name, "Dp"}, 32'(o_seg_dp), 32'(dp));
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(24'h000042, 6'b000000, 1'b0, 2'd3);
      repeat (2) @(negedge clk);
      checkLit("reset", 6'b111111, 7'b0000000, 1'b0);
      checkOutput("resetTick", 32'(o_frame_tick), 32'd0);
      rst = 1'b0;
      ncount = 0;

      // Scenario 1: plain scan, full brightness
      stepTo(1);  checkOutput("s1Dead", 32'(o_seg_enb), 32'(6'b111111));
      stepTo(3);  checkLit("s1Dig0", 6'b111110, 7'b1101101, 1'b0);
      stepTo(11); checkLit("s1Dig1", 6'b111101, 7'b0110011, 1'b0);
      stepTo(19); checkLit("s1Dig2", 6'b111011, 7'b1111110, 1'b0);
      stepTo(43); checkLit("s1Dig5", 6'b011111, 7'b1111110, 1'b0);
      stepTo(47); checkOutput("s1NoTick", 32'(o_frame_tick), 32'd0);
      stepTo(48); checkOutput("s1Tick", 32'(o_frame_tick), 32'd1);
      stepTo(96); checkOutput("s1Tick2", 32'(o_frame_tick), 32'd1);

      // Scenario 2: leading-zero blanking
      applyStimulus(24'h000042, 6'b000000, 1'b1, 2'd3);
      applyReset();
      stepTo(11); checkLit("s2Dig1", 6'b111101, 7'b0110011, 1'b0);
      stepTo(19); checkLit("s2Dig2", 6'b111011, 7'b0000000, 1'b0);
      stepTo(43); checkLit("s2Dig5", 6'b011111, 7'b0000000, 1'b0);

      // Scenario 3: blanking stops at a lit decimal point
      applyStimulus(24'h000000, 6'b000100, 1'b1, 2'd3);
      applyReset();
      stepTo(3);  checkLit("s3Dig0", 6'b111110, 7'b1111110, 1'b0);
      stepTo(11); checkLit("s3Dig1", 6'b111101, 7'b1111110, 1'b0);
      stepTo(19); checkLit("s3Dig2", 6'b111011, 7'b1111110, 1'b1);
      stepTo(27); checkLit("s3Dig3", 6'b110111, 7'b0000000, 1'b0);
      stepTo(43); checkLit("s3Dig5", 6'b011111, 7'b0000000, 1'b0);

      // Scenario 4: dimmest brightness, then a brightness change mid-slot
      applyStimulus(24'h000042, 6'b000000, 1'b0, 2'd0);
      applyReset();
      stepTo(3);  checkOutput("s4Pwm1", 32'(o_seg_enb), 32'(6'b111111));
      stepTo(5);  checkOutput("s4Pwm0", 32'(o_seg_enb), 32'(6'b111110));
      stepTo(6);  checkOutput("s4Pwm1b", 32'(o_seg_enb), 32'(6'b111111));
      stepTo(9);  checkOutput("s4Dead", 32'(o_seg_enb), 32'(6'b111111));
      stepTo(13); checkOutput("s4Dig1", 32'(o_seg_enb), 32'(6'b111101));
      i_bright = 2'd3;
      stepTo(14); checkOutput("s4Bright", 32'(o_seg_enb), 32'(6'b111101));
      stepTo(30);

      // Scenario 5: inputs change mid-frame only show from the next frame
      applyStimulus(24'h000011, 6'b000000, 1'b0, 2'd3);
      applyReset();
      stepTo(3);  checkLit("s5Old0", 6'b111110, 7'b0110000, 1'b0);
      stepTo(26); i_digit = 24'h000099;
      stepTo(43); checkLit("s5Old5", 6'b011111, 7'b1111110, 1'b0);
      stepTo(51); checkLit("s5New0", 6'b111110, 7'b1110011, 1'b0);
      stepTo(59); checkLit("s5New1", 6'b111101, 7'b1110011, 1'b0);
      stepTo(70); i_digit = 24'h550000;
      stepTo(91); checkLit("s5Hold5", 6'b011111, 7'b1111110, 1'b0);
      stepTo(139); checkLit("s5Next5", 6'b011111, 7'b1011011, 1'b0);

      // Scenario 6: reset mid-frame, then value 10
      applyStimulus(24'h000042, 6'b000000, 1'b0, 2'd3);
      applyReset();
      stepTo(37);
      rst = 1'b1;
      applyStimulus(24'h00000A, 6'b000000, 1'b0, 2'd3);
      stepTo(38);
      checkLit("s6Abort", 6'b111111, 7'b0000000, 1'b0);
      checkOutput("s6AbortTick", 32'(o_frame_tick), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ncount = 0;
      stepTo(1); checkOutput("s6Dead", 32'(o_seg_enb), 32'(6'b111111));
`ifdef SEG_SCAN_HEX_DEC_EN
      stepTo(3); checkLit("s6Hex", 6'b111110, 7'b1110111, 1'b0);
`else
      stepTo(3); checkLit("s6Hex", 6'b111110, 7'b0000000, 1'b0);
`endif
      stepTo(47);
      rst = 1'b1;
      stepTo(48);
      checkOutput("s6NoPartialTick", 32'(o_frame_tick), 32'd0);
      checkOutput("s6ResetEnb", 32'(o_seg_enb), 32'(6'b111111));
      @(negedge clk);
      rst = 1'b0;
      ncount = 0;
      stepTo(12);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
